// File: rtl/decode_stage.sv
// Decode stage of the multicycle MIPS datapath: captures the fetched instruction,
// generates control, and reads operands from the internal register file with write-back bypass.
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic        stage2,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  shamt,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext,
    output logic [25:0] jump_addr,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        branch,
    output logic        branch_ne,
    output logic        jump,
    output logic        illegal,
    output logic        stage3
);

    typedef enum logic {IDLE, DONE} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       illegal;
        logic [4:0] dest;
    } ctrl_t;

    state_t      state, state_nx;
    ctrl_t       dec, ctl;
    logic [31:0] regs [32];
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [31:0] rs_rd, rt_rd;

    assign rs_a = instr_in[25:21];
    assign rt_a = instr_in[20:16];
    assign rd_a = instr_in[15:11];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (stage2)  state_nx = DONE;
            DONE: if (!stage2) state_nx = IDLE;
            default:           state_nx = IDLE;
        endcase
    end

    assign stage3 = (state == DONE);

    always_comb begin
        dec = '0;
        case (instr_in[31:26])
            6'h00: begin
                case (instr_in[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00: begin
                        dec.reg_write = 1'b1;
                        dec.dest      = rd_a;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h08: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.dest      = rt_a;
            end
            6'h23: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.dest      = rt_a;
            end
            6'h2B: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            6'h04: dec.branch = 1'b1;
            6'h05: begin
                dec.branch    = 1'b1;
                dec.branch_ne = 1'b1;
            end
            6'h02:   dec.jump    = 1'b1;
            default: dec.illegal = 1'b1;
        endcase
    end

    // Same-edge write-back wins over the stale array value; r0 is hard-wired to zero.
    always_comb begin
        rs_rd = regs[rs_a];
        rt_rd = regs[rt_a];
        if (wb_en && wb_addr == rs_a) rs_rd = wb_data;
        if (wb_en && wb_addr == rt_a) rt_rd = wb_data;
        if (rs_a == 5'd0) rs_rd = '0;
        if (rt_a == 5'd0) rt_rd = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctl       <= '0;
            opcode    <= '0;
            funct     <= '0;
            shamt     <= '0;
            rs_data   <= '0;
            rt_data   <= '0;
            imm_ext   <= '0;
            jump_addr <= '0;
        end else if (stage2) begin
            ctl       <= dec;
            opcode    <= instr_in[31:26];
            funct     <= instr_in[5:0];
            shamt     <= instr_in[10:6];
            rs_data   <= rs_rd;
            rt_data   <= rt_rd;
            imm_ext   <= {{16{instr_in[15]}}, instr_in[15:0]};
            jump_addr <= instr_in[25:0];
        end
    end

    assign reg_write = ctl.reg_write;
    assign mem_read  = ctl.mem_read;
    assign mem_write = ctl.mem_write;
    assign alu_src   = ctl.alu_src;
    assign branch    = ctl.branch;
    assign branch_ne = ctl.branch_ne;
    assign jump      = ctl.jump;
    assign illegal   = ctl.illegal;
    assign dest_reg  = ctl.dest;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus scoreboard of expected
// decodes, with hand sequences for reset, bypass, r0 and back-to-back accepts.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        stage2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, dest_reg;
    logic [31:0] rs_data, rt_data, imm_ext;
    logic [25:0] jump_addr;
    logic        reg_write, mem_read, mem_write, alu_src, branch, branch_ne, jump, illegal;
    logic        stage3;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .stage2(stage2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .opcode(opcode), .funct(funct), .shamt(shamt),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
        .jump_addr(jump_addr), .dest_reg(dest_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .branch(branch), .branch_ne(branch_ne), .jump(jump),
        .illegal(illegal), .stage3(stage3)
    );

    // ctl bit order: {reg_write, mem_read, mem_write, alu_src, branch, branch_ne, jump, illegal}
    typedef struct {
        logic [31:0] instr;
        logic [7:0]  ctl;
        logic [4:0]  dst;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        logic [7:0]  ctl;
        logic [4:0]  dst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;
    vec_t        vt [13];

    function automatic logic [7:0] dut_ctl();
        return {reg_write, mem_read, mem_write, alu_src, branch, branch_ne, jump, illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic wbe,
                                         input logic [4:0] wba, input logic [31:0] wbd);
        if (r == 5'd0) return 32'h0;
        if (wbe && wba == r) return wbd;
        return model[r];
    endfunction

    task automatic step(input logic s2, input logic [31:0] ins, input logic wbe,
                        input logic [4:0] wba, input logic [31:0] wbd,
                        input logic [7:0] ctl, input logic [4:0] dst);
        exp_t e;
        stage2   = s2;
        instr_in = ins;
        wb_en    = wbe;
        wb_addr  = wba;
        wb_data  = wbd;
        if (s2) begin
            e.instr = ins;
            e.rs_v  = opnd(ins[25:21], wbe, wba, wbd);
            e.rt_v  = opnd(ins[20:16], wbe, wba, wbd);
            e.ctl   = ctl;
            e.dst   = dst;
            sb.push_back(e);
        end
        if (wbe && wba != 5'd0) model[wba] = wbd;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 8'h00, 5'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b0, 32'h0, 1'b1, a, d, 8'h00, 5'd0);
    endtask

    task automatic acc(input logic [31:0] ins, input logic [7:0] ctl, input logic [4:0] dst);
        step(1'b1, ins, 1'b0, 5'd0, 32'h0, ctl, dst);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stage3"}, 32'(stage3), 32'h0);
        chk({tag, "_ctl"}, 32'(dut_ctl()), 32'h0);
        chk({tag, "_dest"}, 32'(dest_reg), 32'h0);
        chk({tag, "_rs"}, rs_data, 32'h0);
        chk({tag, "_rt"}, rt_data, 32'h0);
        chk({tag, "_imm"}, imm_ext, 32'h0);
        chk({tag, "_fields"}, {opcode, funct, shamt, 15'h0}, 32'h0);
        chk({tag, "_jaddr"}, 32'(jump_addr), 32'h0);
    endtask

    initial begin
        vt[0]  = '{32'h00A62020, 8'h80, 5'd4};   // add r4,r5,r6
        vt[1]  = '{32'h00221822, 8'h80, 5'd3};   // sub
        vt[2]  = '{32'h00221824, 8'h80, 5'd3};   // and
        vt[3]  = '{32'h00221825, 8'h80, 5'd3};   // or
        vt[4]  = '{32'h0022182A, 8'h80, 5'd3};   // slt
        vt[5]  = '{32'h00021140, 8'h80, 5'd2};   // sll r2,r2,5
        vt[6]  = '{32'h2027FFFF, 8'h90, 5'd7};   // addi r7,r1,-1
        vt[7]  = '{32'h8CA8FFFC, 8'hD0, 5'd8};   // lw
        vt[8]  = '{32'hACA80010, 8'h30, 5'd0};   // sw
        vt[9]  = '{32'h10A80004, 8'h08, 5'd0};   // beq
        vt[10] = '{32'h14A8FFFE, 8'h0C, 5'd0};   // bne
        vt[11] = '{32'h08000100, 8'h02, 5'd0};   // j
        vt[12] = '{32'h00221821, 8'h01, 5'd0};   // unlisted funct
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        fork
            forever begin
                @(negedge clock);
                if (stage3 && !reset) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'(sb.size()), 32'h1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("opcode", 32'(opcode), 32'(e.instr[31:26]));
                        chk("funct", 32'(funct), 32'(e.instr[5:0]));
                        chk("shamt", 32'(shamt), 32'(e.instr[10:6]));
                        chk("imm_ext", imm_ext, {{16{e.instr[15]}}, e.instr[15:0]});
                        chk("jump_addr", 32'(jump_addr), 32'(e.instr[25:0]));
                        chk("rs_data", rs_data, e.rs_v);
                        chk("rt_data", rt_data, e.rt_v);
                        chk("ctl", 32'(dut_ctl()), 32'(e.ctl));
                        chk("dest_reg", 32'(dest_reg), 32'(e.dst));
                    end
                end
            end
        join_none

        // Reset with stage2 asserted
        reset = 1'b1; stage2 = 1'b1; instr_in = 32'hFFFFFFFF;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        #3;
        chk_zero("rst_async");
        @(posedge clock); #1;
        chk_zero("rst_edge");
        reset = 1'b0;
        idle(1);
        chk("idle_stage3", 32'(stage3), 32'h0);

        // add with r5 written beforehand
        wr(5'd5, 32'h000000AA);
        acc(32'h00A62020, 8'h80, 5'd4);
        chk("add_rs", rs_data, 32'h000000AA);
        chk("add_stage3", 32'(stage3), 32'h1);

        // lw accepted on the same edge as a write to its rs
        step(1'b1, 32'h8CA8FFFC, 1'b1, 5'd5, 32'h00001234, 8'hD0, 5'd8);
        chk("lw_bypass", rs_data, 32'h00001234);

        // r0 stays zero, both from a prior write and a same-edge write
        wr(5'd0, 32'hFFFFFFFF);
        acc(32'h00062020, 8'h80, 5'd4);
        chk("r0_read", rs_data, 32'h0);
        step(1'b1, 32'h00002020, 1'b1, 5'd0, 32'hFFFFFFFF, 8'h80, 5'd4);
        chk("r0_same_edge", rs_data, 32'h0);

        // illegal opcode, then illegal funct
        acc(32'hFC221820, 8'h01, 5'd0);
        acc(32'h0022183F, 8'h01, 5'd0);
        chk("ill_stage3", 32'(stage3), 32'h1);
        idle(1);

        // preload every register, then run the table with background write-backs
        for (int k = 1; k < 32; k++) wr(5'(k), 32'h01010101 * k + 32'h00A5_0000);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 13; i++) begin
                step(1'b1, vt[i].instr, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     $urandom, vt[i].ctl, vt[i].dst);
                if ($urandom_range(0, 2) == 0) idle(1);
            end
        end
        idle(1);

        // beq, bne, j back to back then stage2 low
        acc(32'h10A80004, 8'h08, 5'd0);
        chk("seq1_stage3", 32'(stage3), 32'h1);
        acc(32'h14A8FFFE, 8'h0C, 5'd0);
        chk("seq2_stage3", 32'(stage3), 32'h1);
        acc(32'h08000100, 8'h02, 5'd0);
        chk("seq3_stage3", 32'(stage3), 32'h1);
        idle(1);
        chk("seq_drop_stage3", 32'(stage3), 32'h0);
        chk("seq_hold_jump", 32'(jump), 32'h1);
        chk("seq_hold_bne", 32'(branch_ne), 32'h0);
        idle(2);
        chk("seq_hold_op", 32'(opcode), 32'h02);
        chk("seq_hold_jaddr", 32'(jump_addr), 32'h100);

        // reset in the middle of a DONE cycle
        acc(32'h2027FFFF, 8'h90, 5'd7);
        #6;
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clock); #1;
        reset = 1'b0;
        idle(1);
        chk("post_rst_stage3", 32'(stage3), 32'h0);

        // every register reads back zero after reset
        for (int k = 1; k < 32; k++) begin
            acc({6'd0, 5'(k), 5'(32 - k), 5'd0, 5'd0, 6'h20}, 8'h80, 5'd0);
            chk("clr_rs", rs_data, 32'h0);
        end
        idle(2);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
